// File: rtl/vector_store_unit.sv
// Vector store unit: serialises a captured 32/128/512-bit store into 128-bit
// write beats with byte strobes on a valid/ready memory write channel.
module vector_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [511:0]      st_data,
  output logic              wvalid,
  input  logic              wready,
  output logic [ADDR_W-1:0] waddr,
  output logic [127:0]      wdata,
  output logic [15:0]       wstrb,
  output logic              wlast,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_32  = 2'b00;
  localparam logic [1:0] SZ_128 = 2'b01;
  localparam logic [1:0] SZ_512 = 2'b10;

  state_t              state;
  logic [1:0]          beat;
  logic [1:0]          size_q;
  logic [ADDR_W-1:2]   addr_q;
  logic [511:0]        data_q;
  logic                err_q;
  logic                illegal;
  logic                is_last;

  // Alignment rule grows with the store size; size 11 is never legal.
  always_comb begin
    illegal = 1'b0;
    case (st_size)
      SZ_32:   illegal = (st_addr[1:0] != 2'b00);
      SZ_128:  illegal = (st_addr[3:0] != 4'h0);
      SZ_512:  illegal = (st_addr[5:0] != 6'h00);
      default: illegal = 1'b1;
    endcase
  end

  assign is_last = (beat == ((size_q == SZ_512) ? 2'd3 : 2'd0));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      beat   <= 2'd0;
      size_q <= 2'b00;
      addr_q <= '0;
      // NOTE: the wide data capture register is reset too, so outputs are
      // fully defined from reset; it is a flop bank, not a RAM.
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (st_valid) begin
            size_q <= st_size;
            addr_q <= st_addr[ADDR_W-1:2];
            data_q <= st_data;
            beat   <= 2'd0;
            err_q  <= illegal;
            state  <= illegal ? DONE : SEND;
          end
        end
        SEND: begin
          if (wready) begin
            if (is_last) state <= DONE;
            else         beat  <= beat + 2'd1;
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so reset clears them
  // asynchronously and a stalled beat stays stable while wready is low.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    st_ready = (state == IDLE);
    busy     = (state != IDLE);
    done     = (state == DONE);
    err      = (state == DONE) && err_q;
    wvalid   = 1'b0;
    waddr    = '0;
    wdata    = '0;
    wstrb    = '0;
    wlast    = 1'b0;
    if (state == SEND) begin
      wvalid = 1'b1;
      wlast  = is_last;
      waddr  = {addr_q[ADDR_W-1:4], 4'h0} + ADDR_W'({beat, 4'h0});
      case (size_q)
        SZ_512: begin
          wdata = data_q[{beat, 7'd0} +: 128];
          wstrb = 16'hFFFF;
        end
        SZ_128: begin
          wdata = data_q[127:0];
          wstrb = 16'hFFFF;
        end
        default: begin
          wdata = {96'd0, data_q[31:0]} << {addr_q[3:2], 5'd0};
          wstrb = 16'h000F << {addr_q[3:2], 2'b00};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed self-checking bench for vector_store_unit: beat sequencing,
// strobes, stalls, rejects, request hold-off and asynchronous reset.
module tb_vector_store_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         st_valid;
  logic         st_ready;
  logic [1:0]   st_size;
  logic [31:0]  st_addr;
  logic [511:0] st_data;
  logic         wvalid;
  logic         wready;
  logic [31:0]  waddr;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         busy;
  logic         done;
  logic         err;

  int errors = 0;
  int checks = 0;

  logic [511:0] vec_a;
  logic [511:0] vec_b;

  vector_store_unit #(.ADDR_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_size  (st_size),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .wvalid   (wvalid),
    .wready   (wready),
    .waddr    (waddr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sample one time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] make_vec(input logic [31:0] base);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = base + 32'(i);
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".st_ready"}, 128'(st_ready), 128'd1);
    check({tag, ".busy"},     128'(busy),     128'd0);
    check({tag, ".done"},     128'(done),     128'd0);
    check({tag, ".err"},      128'(err),      128'd0);
    check({tag, ".wvalid"},   128'(wvalid),   128'd0);
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a, input logic [127:0] d,
                            input logic [15:0] s, input logic l);
    check({tag, ".wvalid"},   128'(wvalid),   128'd1);
    check({tag, ".waddr"},    128'(waddr),    128'(a));
    check({tag, ".wdata"},    wdata,          d);
    check({tag, ".wstrb"},    128'(wstrb),    128'(s));
    check({tag, ".wlast"},    128'(wlast),    128'(l));
    check({tag, ".st_ready"}, 128'(st_ready), 128'd0);
    check({tag, ".done"},     128'(done),     128'd0);
  endtask

  task automatic check_done(input string tag, input logic e);
    check({tag, ".done"},     128'(done),     128'd1);
    check({tag, ".err"},      128'(err),      128'(e));
    check({tag, ".wvalid"},   128'(wvalid),   128'd0);
    check({tag, ".busy"},     128'(busy),     128'd1);
    check({tag, ".st_ready"}, 128'(st_ready), 128'd0);
  endtask

  // Present a request for one edge and drop st_valid afterwards.
  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [511:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    check("issue.st_ready", 128'(st_ready), 128'd1);
    tick();
    st_valid = 1'b0;
    st_data  = '1;
    st_addr  = 32'hFFFF_FFFF;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rej_size [4];
    logic [31:0] rej_addr [4];
    rej_size = '{2'b01, 2'b11, 2'b00, 2'b10};
    rej_addr = '{32'h0000_0004, 32'h0000_0000, 32'h0000_1001, 32'h0000_2010};

    reset    = 1'b0;
    st_valid = 1'b0;
    st_size  = 2'b00;
    st_addr  = '0;
    st_data  = '0;
    wready   = 1'b0;
    #12;
    check_idle("reset");
    check("reset.waddr", 128'(waddr), 128'd0);
    check("reset.wdata", wdata, 128'd0);
    check("reset.wstrb", 128'(wstrb), 128'd0);
    check("reset.wlast", 128'(wlast), 128'd0);
    reset = 1'b1;
    tick();
    check_idle("post_reset");

    // 32b store into lane 2 with all-ones junk above the word.
    wready = 1'b1;
    issue(2'b00, 32'h0000_1008, {{480{1'b1}}, 32'hDEAD_BEEF});
    check_beat("st32", 32'h0000_1000, {32'h0, 32'hDEAD_BEEF, 64'h0}, 16'h0F00, 1'b1);
    tick();
    check_done("st32.done", 1'b0);
    tick();
    check_idle("st32.idle");

    // 512b store, wready tied high: four back-to-back beats.
    vec_a = make_vec(32'hA000_0000);
    issue(2'b10, 32'h0000_2000, vec_a);
    check_beat("st512.b0", 32'h0000_2000,
               {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000}, 16'hFFFF, 1'b0);
    tick();
    check_beat("st512.b1", 32'h0000_2010, vec_a[255:128], 16'hFFFF, 1'b0);
    tick();
    check_beat("st512.b2", 32'h0000_2020, vec_a[383:256], 16'hFFFF, 1'b0);
    tick();
    check_beat("st512.b3", 32'h0000_2030,
               {32'hA000_000F, 32'hA000_000E, 32'hA000_000D, 32'hA000_000C}, 16'hFFFF, 1'b1);
    tick();
    check_done("st512.done", 1'b0);
    tick();
    check_idle("st512.idle");

    // 512b store with beat 1 stalled for three cycles.
    vec_b = make_vec(32'h5500_0040);
    issue(2'b10, 32'h0000_2000, vec_b);
    check_beat("stall.b0", 32'h0000_2000, vec_b[127:0], 16'hFFFF, 1'b0);
    tick();
    wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_beat("stall.b1_hold", 32'h0000_2010, vec_b[255:128], 16'hFFFF, 1'b0);
      tick();
    end
    wready = 1'b1;
    check_beat("stall.b1", 32'h0000_2010, vec_b[255:128], 16'hFFFF, 1'b0);
    tick();
    check_beat("stall.b2", 32'h0000_2020, vec_b[383:256], 16'hFFFF, 1'b0);
    tick();
    check_beat("stall.b3", 32'h0000_2030, vec_b[511:384], 16'hFFFF, 1'b1);
    tick();
    check_done("stall.done", 1'b0);
    tick();
    check_idle("stall.idle");

    // Rejected requests: misaligned 128b, size 11, misaligned 32b and 512b.
    for (int i = 0; i < 4; i++) begin
      issue(rej_size[i], rej_addr[i], vec_a);
      check_done("reject.done", 1'b1);
      tick();
      check_idle("reject.idle");
    end

    // st_valid held through SEND/DONE with changing data: second request waits.
    wready   = 1'b0;
    st_valid = 1'b1;
    st_size  = 2'b01;
    st_addr  = 32'h0000_3000;
    st_data  = vec_a;
    check("hold.st_ready", 128'(st_ready), 128'd1);
    tick();
    st_data = vec_b;
    st_addr = 32'h0000_3010;
    check_beat("hold.first", 32'h0000_3000, vec_a[127:0], 16'hFFFF, 1'b1);
    tick();
    check_beat("hold.first_stall", 32'h0000_3000, vec_a[127:0], 16'hFFFF, 1'b1);
    wready = 1'b1;
    tick();
    check_done("hold.done", 1'b0);
    tick();
    check_idle("hold.idle");
    tick();
    st_valid = 1'b0;
    check_beat("hold.second", 32'h0000_3010, vec_b[127:0], 16'hFFFF, 1'b1);
    tick();
    check_done("hold.done2", 1'b0);
    tick();
    check_idle("hold.idle2");

    // Reset asserted during beat 2 of a 512b store.
    issue(2'b10, 32'h0000_2000, vec_a);
    tick();
    tick();
    check_beat("rst.b2", 32'h0000_2020, vec_a[383:256], 16'hFFFF, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("rst.wvalid", 128'(wvalid), 128'd0);
    check("rst.busy",   128'(busy),   128'd0);
    check("rst.done",   128'(done),   128'd0);
    check("rst.err",    128'(err),    128'd0);
    #2 reset = 1'b1;
    tick();
    check_idle("rst.after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
